// File: rtl/imem_boot_ctrl_pkg.sv
// ============================================================================
// imem_boot_ctrl_pkg : shared state encodings and defaults for the boot loader
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_CNT  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4
  } state_e;

  localparam logic [7:0]  C_HDR_BYTE    = 8'hA5;
  localparam int unsigned C_TIMEOUT_CYC = 32'd1000000;

endpackage

`default_nettype wire

// File: rtl/imem_byte_packer.sv
// ============================================================================
// imem_byte_packer : assembles MSB-first bytes into words and XORs a checksum
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done,
  output logic [7:0]  o_csum,
  output logic        o_last_byte
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_done;
  logic [7:0]  r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx  <= 2'd0;
      r_shift     <= 24'd0;
      r_word      <= 32'd0;
      r_word_done <= 1'b0;
      r_csum      <= 8'd0;
    end else begin
      r_word_done <= 1'b0;
      if (i_clear) begin
        r_byte_idx <= 2'd0;
        r_shift    <= 24'd0;
        r_csum     <= 8'd0;
      end else if (i_byte_valid) begin
        r_csum     <= r_csum ^ i_byte;
        r_byte_idx <= r_byte_idx + 2'd1;
        r_shift    <= {r_shift[15:0], i_byte};
        // Word is held separately so the next byte can shift in during the write cycle
        if (r_byte_idx == 2'd3) begin
          r_word      <= {r_shift, i_byte};
          r_word_done <= 1'b1;
        end
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_done = r_word_done;
  assign o_csum      = r_csum;
  assign o_last_byte = (r_byte_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// ============================================================================
// imem_boot_ctrl : UART boot loader and fetch arbiter for the instruction RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC,
  parameter logic [7:0]  HDR_BYTE    = C_HDR_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_boot_req,
  input  logic [31:0]       i_fetch_addr,
  output logic [31:0]       o_fetch_instr,
  output logic              o_cpu_hold,
  output logic              o_cpu_restart,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [31:0] C_DEPTH = 32'd1 << ADDR_W;

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W:0]   r_n_eff;
  logic [ADDR_W-1:0] r_word_ptr;
  logic [31:0]       r_idle;
  logic              r_load_err;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_cpu_restart;

  logic              w_hdr_ok;
  logic              w_active;
  logic              w_timed;
  logic              w_byte_in;
  logic [31:0]       w_cnt_ext;
  logic [31:0]       w_cnt_eff;
  logic              w_cnt_ok;
  logic              w_last_word;
  logic              w_set_err;
  logic              w_done_load;
  logic              w_word_done;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic [7:0]        w_csum;
  logic              w_unused_fetch;

  assign w_hdr_ok  = i_rx_valid && (r_state == S_HDR) && (i_rx_data == HDR_BYTE);
  assign w_active  = (r_state == S_CNT) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timed   = w_active && !i_rx_valid && (r_idle == TIMEOUT_CYC - 1);
  assign w_byte_in = i_rx_valid && (r_state == S_DATA);

  // A count of zero stands for a full RAM image
  assign w_cnt_ext   = {24'd0, i_rx_data};
  assign w_cnt_eff   = (i_rx_data == 8'd0) ? C_DEPTH : w_cnt_ext;
  assign w_cnt_ok    = (w_cnt_eff <= C_DEPTH);
  assign w_last_word = ({1'b0, r_word_ptr} == (r_n_eff - 1'b1));

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_hdr_ok),
    .i_byte_valid (w_byte_in),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_done  (w_word_done),
    .o_csum       (w_csum),
    .o_last_byte  (w_last_byte)
  );

  always_comb begin
    w_next      = r_state;
    w_set_err   = 1'b0;
    w_done_load = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_hdr_ok) w_next = S_CNT;
      end
      S_CNT: begin
        if (w_timed) begin
          w_set_err = 1'b1;
          w_next    = S_HDR;
        end else if (i_rx_valid) begin
          if (w_cnt_ok) begin
            w_next = S_DATA;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_HDR;
          end
        end
      end
      S_DATA: begin
        if (w_timed) begin
          w_set_err = 1'b1;
          w_next    = S_HDR;
        end else if (i_rx_valid && w_last_byte && w_last_word) begin
          w_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_timed) begin
          w_set_err = 1'b1;
          w_next    = S_HDR;
        end else if (i_rx_valid) begin
          if (i_rx_data == w_csum) begin
            w_done_load = 1'b1;
            w_next      = S_RUN;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_HDR;
          end
        end
      end
      S_RUN: begin
        if (i_boot_req) w_next = S_HDR;
      end
      default: w_next = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_HDR;
      r_n_eff        <= '0;
      r_word_ptr     <= '0;
      r_idle         <= 32'd0;
      r_load_err     <= 1'b0;
      r_words_loaded <= '0;
      r_cpu_restart  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cpu_restart <= w_done_load;
      if (w_hdr_ok)       r_load_err <= 1'b0;
      else if (w_set_err) r_load_err <= 1'b1;
      if (r_state == S_CNT && i_rx_valid) r_n_eff <= w_cnt_eff[ADDR_W:0];
      if (w_hdr_ok)                                r_word_ptr <= '0;
      else if (w_word_done && r_state != S_RUN)    r_word_ptr <= r_word_ptr + 1'b1;
      if (w_done_load) r_words_loaded <= r_n_eff;
      if (i_rx_valid || !w_active || w_timed) r_idle <= 32'd0;
      else                                    r_idle <= r_idle + 32'd1;
    end
  end

  assign o_cpu_hold     = (r_state != S_RUN);
  assign o_cpu_restart  = r_cpu_restart;
  assign o_mem_we       = w_word_done && (r_state != S_RUN);
  assign o_mem_wdata    = w_word;
  assign o_mem_addr     = (r_state == S_RUN) ? i_fetch_addr[ADDR_W+1:2] : r_word_ptr;
  assign o_fetch_instr  = (r_state == S_RUN) ? i_mem_rdata : 32'h0000_0000;
  assign o_load_err     = r_load_err;
  assign o_words_loaded = r_words_loaded;

  assign w_unused_fetch = ^{i_fetch_addr[31:ADDR_W+2], i_fetch_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
// ============================================================================
// tb_imem_boot_ctrl : scoreboard + table-driven bench for imem_boot_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        boot_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        cpu_hold;
  logic        cpu_restart;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_err;
  logic [8:0]  words_loaded;

  logic [31:0] ram [256];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] fa;
    logic [7:0]  exp_addr;
    logic [31:0] exp_instr;
  } fvec_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  fvec_t       fv[5];
  int          n_checks;
  int          n_err;
  int          n_restart;

  imem_boot_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(16), .HDR_BYTE(8'hA5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .i_boot_req     (boot_req),
    .i_fetch_addr   (fetch_addr),
    .o_fetch_instr  (fetch_instr),
    .o_cpu_hold     (cpu_hold),
    .o_cpu_restart  (cpu_restart),
    .o_mem_addr     (mem_addr),
    .o_mem_we       (mem_we),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata),
    .o_load_err     (load_err),
    .o_words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the next expected one
  always @(negedge clk) begin
    if (cpu_restart === 1'b1) n_restart++;
    if (mem_we !== 1'b0 && rst_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_we", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", {24'd0, mem_addr}, {24'd0, w.addr});
        check("write_data", mem_wdata, w.data);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    sync();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input bit corrupt);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'd0;
    for (int i = 0; i < frame_words.size(); i++) begin
      wr_t e;
      w = frame_words[i];
      e.addr = i[7:0];
      e.data = w;
      exp_q.push_back(e);
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    drive_byte(8'hA5);
    drive_byte(n);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      for (int b = 3; b >= 0; b--) drive_byte(w[8*b +: 8]);
    end
    drive_byte(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic check_good_load(input logic [8:0] n_eff);
    @(negedge clk);
    check("restart_pulse", {31'd0, cpu_restart}, 32'd1);
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    check("load_err_clear", {31'd0, load_err}, 32'd0);
    check("words_loaded", {23'd0, words_loaded}, {23'd0, n_eff});
    @(negedge clk);
    check("restart_one_cycle", {31'd0, cpu_restart}, 32'd0);
    sync();
  endtask

  task automatic do_boot_req();
    boot_req = 1'b1;
    sync();
    boot_req = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    n_restart  = 0;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    boot_req   = 1'b0;
    fetch_addr = 32'd0;

    fv[0] = '{fa: 32'h0000_0000, exp_addr: 8'd0, exp_instr: 32'h1122_3344};
    fv[1] = '{fa: 32'h0000_0004, exp_addr: 8'd1, exp_instr: 32'hA5B6_C7D8};
    fv[2] = '{fa: 32'h0000_0007, exp_addr: 8'd1, exp_instr: 32'hA5B6_C7D8};
    fv[3] = '{fa: 32'h0000_0400, exp_addr: 8'd0, exp_instr: 32'h1122_3344};
    fv[4] = '{fa: 32'hFFFF_F005, exp_addr: 8'd1, exp_instr: 32'hA5B6_C7D8};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_restart", {31'd0, cpu_restart}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_words", {23'd0, words_loaded}, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    rst_n = 1'b1;
    sync();

    // Single-word frame A5 01 08 00 00 0E 06
    frame_words = '{32'h0800_000E};
    send_frame(8'd1, 1'b0);
    check_good_load(9'd1);
    fetch_addr = 32'd0;
    #1;
    check("run_fetch0", fetch_instr, 32'h0800_000E);

    // boot_req with a simultaneous A5: byte dropped, then bad-checksum frame
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    sync();
    boot_req = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("bootreq_hold", {31'd0, cpu_hold}, 32'd1);
    check("hdr_instr_nop", fetch_instr, 32'd0);
    sync();
    send_frame(8'd1, 1'b1);
    @(negedge clk);
    check("badcs_err", {31'd0, load_err}, 32'd1);
    check("badcs_hold", {31'd0, cpu_hold}, 32'd1);
    check("badcs_norestart", {31'd0, cpu_restart}, 32'd0);
    sync();

    // Garbage before header, then a two-word frame
    drive_byte(8'h00);
    drive_byte(8'hFF);
    drive_byte(8'h3C);
    frame_words = '{32'h1122_3344, 32'hA5B6_C7D8};
    send_frame(8'd2, 1'b0);
    check_good_load(9'd2);

    // Fetch path table
    for (int i = 0; i < 5; i++) begin
      fetch_addr = fv[i].fa;
      #1;
      check($sformatf("fetch_addr[%0d]", i), {24'd0, mem_addr}, {24'd0, fv[i].exp_addr});
      check($sformatf("fetch_instr[%0d]", i), fetch_instr, fv[i].exp_instr);
      sync();
    end

    // Timeout after two data bytes
    do_boot_req();
    drive_byte(8'hA5);
    drive_byte(8'd1);
    drive_byte(8'h12);
    drive_byte(8'h34);
    repeat (8) @(negedge clk);
    check("no_early_timeout", {31'd0, load_err}, 32'd0);
    for (int i = 0; i < 40 && load_err !== 1'b1; i++) @(negedge clk);
    check("timeout_err", {31'd0, load_err}, 32'd1);
    check("timeout_hold", {31'd0, cpu_hold}, 32'd1);
    sync();
    frame_words = '{32'hCAFE_F00D};
    send_frame(8'd1, 1'b0);
    check_good_load(9'd1);

    // Asynchronous reset in the middle of the data phase
    do_boot_req();
    drive_byte(8'hA5);
    drive_byte(8'd2);
    drive_byte(8'h11);
    drive_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_we", {31'd0, mem_we}, 32'd0);
    check("midrst_words", {23'd0, words_loaded}, 32'd0);
    check("midrst_err", {31'd0, load_err}, 32'd0);
    check("midrst_instr", fetch_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();

    // Full-depth image: count byte 0 means 256 words
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(i * 32'h0102_0304 + 32'h0BAD_F00D);
    send_frame(8'd0, 1'b0);
    check_good_load(9'd256);
    fetch_addr = 32'h0000_03FC;
    #1;
    check("full_last_word", fetch_instr, 32'd255 * 32'h0102_0304 + 32'h0BAD_F00D);

    repeat (2) @(negedge clk);
    check("restart_count", n_restart, 32'd4);
    check("writes_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot-load controller and arbiter for the single-cycle CPU's word-addressed instruction RAM, which replaces the fixed instruction ROM.
- Two requesters share the RAM: a UART byte loader that writes a program image, and the CPU fetch path.
- Holds the CPU in reset while a framed image arrives, verifies its checksum, then releases the CPU to run from address 0.
- Sits between the UART RX block, the instruction RAM and the CPU PC/reset logic.

Parameters:
- ADDR_W, 8, word-address width; RAM depth is 2^ADDR_W words, and the word index is fetch_addr[ADDR_W+1:2].
- TIMEOUT_CYC, 1000000, maximum idle clocks between bytes inside a frame.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, UART byte received
- rx_data  in  8  received byte
- boot_req  in  1  one-cycle request to re-enter load mode
- fetch_addr  in  32  CPU PC (byte address)
- fetch_instr  out  32  instruction to CPU
- cpu_hold  out  1  CPU must not advance PC
- cpu_restart  out  1  one-cycle pulse: CPU PC returns to 0
- mem_addr  out  ADDR_W  RAM word address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM combinational read data
- load_err  out  1  sticky frame error
- words_loaded  out  ADDR_W+1  word count of last accepted image

Behaviour:
- Reset values: state=S_HDR, cpu_hold=1, cpu_restart=0, mem_we=0, load_err=0, words_loaded=0. All internal counters and the checksum are 0.
- Frame format: HDR_BYTE, then count byte N, then 4*N data bytes (each word MSB first), then checksum byte.
  - N=0 means 2^ADDR_W words. N>2^ADDR_W is an error.
  - The checksum is the XOR of all data bytes only.
- States:
  - S_HDR: waits for rx_data==HDR_BYTE. Any other byte is ignored. On a valid header: clear load_err, word_ptr, byte_idx and csum, go to S_CNT.
  - S_CNT: latches N. An invalid N sets load_err and returns to S_HDR.
  - S_DATA: shifts bytes into a 32-bit assembly register. On the 4th byte, mem_we=1 for exactly one cycle with mem_addr=word_ptr and mem_wdata={b0,b1,b2,b3}; then word_ptr increments. After word N is written, go to S_CSUM.
  - S_CSUM: if the byte equals csum, set words_loaded=N_eff, pulse cpu_restart for one cycle, go to S_RUN. Otherwise set load_err=1 and go to S_HDR.
  - S_RUN: cpu_hold=0. mem_addr=fetch_addr[ADDR_W+1:2], mem_we=0, fetch_instr=mem_rdata. rx_valid is ignored. boot_req moves to S_HDR, with cpu_hold=1 from the next cycle.
- Outside S_RUN, fetch_instr=32'h00000000 (NOP) and mem_addr is driven by word_ptr.
- cpu_restart asserts in the same cycle as the S_CSUM→S_RUN transition register update, so cpu_hold is 0 on the following cycle.
- Timeout: an idle counter clears on each rx_valid and counts only in S_CNT, S_DATA and S_CSUM. When it reaches TIMEOUT_CYC-1, set load_err=1 and go to S_HDR. There is no timeout in S_HDR or S_RUN.
- Simultaneous events: boot_req together with rx_valid in S_RUN causes the byte to be dropped. boot_req outside S_RUN is ignored.
- Failed or timed-out frames may leave the RAM partially written. The CPU stays held, and the next good frame overwrites from word 0.
- Reset mid-frame returns everything to reset values. The RAM is not cleared.
- Only 1 byte per rx_valid is accepted. Back-to-back rx_valid on consecutive cycles must be accepted, so no byte may be lost.

Decomposition:
- Shared header file/package: state encodings (S_HDR, S_CNT, S_DATA, S_CSUM, S_RUN), HDR_BYTE, and the default TIMEOUT_CYC.
- Natural sub-module: imem_byte_packer (byte_idx counter, 32-bit shift assembly, XOR checksum, word_done strobe).
- The FSM, timeout counter and address mux stay in the top module.

Test Plan:
- Reset, then bytes A5 01 08 00 00 0E 06 → exactly one mem_we cycle with addr 0 and wdata 32'h0800000E. Then cpu_restart pulses once, cpu_hold=0, and words_loaded=1.
- Same frame with checksum 07 → load_err=1, cpu_hold stays 1, no cpu_restart, state back to S_HDR. A following good frame clears load_err.
- Bytes 00 FF 3C before A5 → all ignored; the following 2-word frame writes addresses 0 and 1 in order with correct MSB-first words.
- In S_RUN with fetch_addr=32'h0000_0004 → mem_addr=1 and fetch_instr=mem_rdata. In S_HDR, fetch_instr=0.
- Frame stalls after 2 data bytes for TIMEOUT_CYC cycles (use a small TIMEOUT_CYC=16) → load_err=1, S_HDR, and no mem_we for the partial word.
- Reset asserted mid-S_DATA → all outputs at reset values. Also: boot_req together with rx_valid=A5 in S_RUN → cpu_hold=1 next cycle, and the A5 is not taken as a header.
